// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential signed divider.
//   ST_IDLE/ST_RUN/ST_FIX/ST_DONE : state encodings
//   state_t                       : FSM state type built on those encodings
//   cnt_width(n)                  : step-counter width able to hold 0..n
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   r      in  nb+1 : partial remainder
//   q      in  nb   : quotient / remaining dividend bits
//   b      in  nb   : divisor magnitude
//   r_next out nb+1 : partial remainder after the step
//   q_next out nb   : quotient after the step (new bit in LSB)
module div_step #(
    parameter int nb = 8
) (
    input  logic [nb:0]   r,
    input  logic [nb-1:0] q,
    input  logic [nb-1:0] b,
    output logic [nb:0]   r_next,
    output logic [nb-1:0] q_next
);

    logic [nb:0]   r_shift;
    logic [nb+1:0] diff;

    assign r_shift = {r[nb-1:0], q[nb-1]};
    // One extra bit so the sign of the trial subtraction is visible.
    assign diff    = {1'b0, r_shift} - {2'b00, b};

    always_comb begin
        q_next = {q[nb-2:0], 1'b0};
        r_next = r_shift;
        if (!diff[nb+1]) begin
            r_next    = diff[nb:0];
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential signed divider, restoring algorithm on magnitudes
// with a sign fix-up; one quotient bit per clock.
//   clk         in   : clock
//   rst         in   : synchronous active-high reset
//   start       in   : latch A/B and begin a divide (aborts one in flight)
//   A, B        in   : dividend, divisor (two's complement, nb bits)
//   Quotient    out  : signed quotient, rounds toward zero
//   Remainder   out  : signed remainder, sign of the dividend
//   ready       out  : high in IDLE/DONE
//   div_by_zero out  : last completed divide had B = 0
//   overflow    out  : last completed divide was min / -1
//
// state | meaning
// IDLE  | after reset, outputs zero
// RUN   | one restoring step per cycle, nb steps
// FIX   | sign fix-up, outputs written
// DONE  | result held until next start
module seq_divider
    import div_pkg::*;
#(
    parameter int nb = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [nb-1:0] A,
    input  logic [nb-1:0] B,
    output logic [nb-1:0] Quotient,
    output logic [nb-1:0] Remainder,
    output logic          ready,
    output logic          div_by_zero,
    output logic          overflow
);

    localparam int CW = cnt_width(nb);
    localparam logic [nb-1:0] MIN_VAL = {1'b1, {(nb-1){1'b0}}};

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [nb-1:0] mag_b, a_hold, q, q_step;
    logic [nb:0]   r, r_step;
    logic          sign_q, sign_r, dbz_pend, ovf_pend;
    logic [nb-1:0] mag_a_in, mag_b_in;

    // |min| wraps to itself, which reads correctly as the unsigned 2^(nb-1).
    assign mag_a_in = A[nb-1] ? -A : A;
    assign mag_b_in = B[nb-1] ? -B : B;
    assign ready    = (state == IDLE) || (state == DONE);

    div_step #(.nb(nb)) u_step (
        .r      (r),
        .q      (q),
        .b      (mag_b),
        .r_next (r_step),
        .q_next (q_step)
    );

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (cnt == CW'(nb - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            default: state_next = state;
        endcase
        if (start) state_next = (B == '0) ? FIX : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mag_b       <= '0;
            a_hold      <= '0;
            q           <= '0;
            r           <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                mag_b    <= mag_b_in;
                a_hold   <= A;
                q        <= mag_a_in;
                r        <= '0;
                cnt      <= '0;
                sign_q   <= A[nb-1] ^ B[nb-1];
                sign_r   <= A[nb-1];
                dbz_pend <= (B == '0);
                ovf_pend <= (A == MIN_VAL) && (B == '1);
            end else begin
                case (state)
                    RUN: begin
                        r   <= r_step;
                        q   <= q_step;
                        cnt <= cnt + CW'(1);
                    end
                    FIX: begin
                        // The min/-1 case needs no special datapath: the
                        // magnitude quotient 2^(nb-1) already wraps to min.
                        if (dbz_pend) begin
                            Quotient  <= '1;
                            Remainder <= a_hold;
                        end else begin
                            Quotient  <= sign_q ? -q : q;
                            Remainder <= sign_r ? -r[nb-1:0] : r[nb-1:0];
                        end
                        div_by_zero <= dbz_pend;
                        overflow    <= ovf_pend;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] A, B;
    logic [7:0] Quotient, Remainder;
    logic       ready, div_by_zero, overflow;

    int total = 0;
    int bad   = 0;

    seq_divider #(.nb(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division rules (truncate toward zero,
    // remainder follows the dividend), plus the two special cases.
    task automatic model(input int a, input int b, output int q, output int r,
                         output int dz, output int ov);
        dz = 0; ov = 0;
        if (b == 0) begin
            q = -1; r = a; dz = 1;
        end else if (a == -128 && b == -1) begin
            q = -128; r = 0; ov = 1;
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Caller is at a negedge; start is driven immediately so a call right
    // after a previous one exercises back-to-back acceptance.
    task automatic measure(input string tag, input int a, input int b);
        int eq, er, edz, eov, lat;
        model(a, b, eq, er, edz, eov);
        lat = 0;
        while (!ready && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, lat, (b == 0) ? 1 : 9);
        chk({tag, "_q"},   {24'b0, Quotient},  eq & 32'hFF);
        chk({tag, "_r"},   {24'b0, Remainder}, er & 32'hFF);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, edz);
        chk({tag, "_ovf"}, {31'b0, overflow},    eov);
    endtask

    task automatic run_div(input string tag, input int a, input int b);
        A = a[7:0]; B = b[7:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        measure(tag, a, b);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int a, b;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 1);
        chk("rst_q", {24'b0, Quotient}, 0);
        chk("rst_r", {24'b0, Remainder}, 0);
        chk("rst_flags", {30'b0, div_by_zero, overflow}, 0);

        run_div("d100_7", 100, 7);
        run_div("dm100_7", -100, 7);
        run_div("d100_m7", 100, -7);
        run_div("ovf", -128, -1);
        run_div("m128_1", -128, 1);
        run_div("dbz", 5, 0);
        run_div("d9_3", 9, 3);

        // Abort: 50/3 replaced on its 4th cycle by 77/8.
        A = 8'd50; B = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        A = 8'd77; B = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        measure("abort", 77, 8);

        // Reset mid-divide.
        A = 8'd100; B = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", {31'b0, ready}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'b0, ready}, 1);
        chk("midrst_q", {24'b0, Quotient}, 0);
        chk("midrst_r", {24'b0, Remainder}, 0);

        // Establish nonzero outputs, then rst together with start.
        run_div("pre", 9, 3);
        A = 8'd100; B = 8'd7; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rststart_ready", {31'b0, ready}, 1);
        chk("rststart_q", {24'b0, Quotient}, 0);
        @(negedge clk);
        chk("rststart_idle", {31'b0, ready}, 1);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            if (i == 0) begin ra = 8'h80; rb = 8'hFF; end
            a = $signed(ra);
            b = $signed(rb);
            run_div("rand", a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential signed integer divider using a radix-2 restoring algorithm on operand magnitudes, with a final sign fix-up. It is the inverse-direction companion to the team's sequential Booth multiplier. It uses the same `start`/`ready` operand handshake, so datapath blocks can issue divides the same way they issue multiplies. One quotient bit is produced per clock.

## Interface
- `nb`, default 8: operand width in bits; must be ≥ 2.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: reset, synchronous and active-high.
- `start` input, 1: sampled every edge; when high, latch operands and begin a divide.
- `A` input, nb: dividend, two's complement.
- `B` input, nb: divisor, two's complement.
- `Quotient` output, nb: signed quotient, registered.
- `Remainder` output, nb: signed remainder, registered.
- `ready` output, 1: high when idle or done; low while a divide is in flight.
- `div_by_zero` output, 1: last completed divide had B = 0.
- `overflow` output, 1: last completed divide was A = −2^(nb−1), B = −1.

## Operation
- States: IDLE, RUN, FIX, DONE. `ready` = 1 in IDLE and DONE.
- Reset: state IDLE; `Quotient`, `Remainder`, `div_by_zero`, `overflow` all 0; counter 0.
- `start` seen in any state (rst low):
  - Latch |A| and |B| as nb-bit unsigned values; |−2^(nb−1)| = 2^(nb−1) fits.
  - Latch sign_q = A[nb−1]^B[nb−1] and sign_r = A[nb−1].
  - Clear the partial remainder R (nb+1 bits) and load Q with |A|; counter = 0.
  - If B = 0, go to FIX with the dbz flag set; otherwise go to RUN.
- A new `start` while busy aborts the current divide and restarts with the new operands.
- RUN step, each cycle:
  - {R,Q} shifted left 1.
  - T = R_shifted − {1'b0,|B|}.
  - If T ≥ 0: R = T and Q[0] = 1; else R = R_shifted and Q[0] = 0.
  - counter += 1. After step nb, go to FIX.
- FIX, one cycle, writes the outputs and goes to DONE:
  - `Quotient` = sign_q ? −Q : Q, truncated to nb bits.
  - `Remainder` = sign_r ? −R[nb−1:0] : R[nb−1:0].
  - Result rounds toward zero; the remainder takes the sign of the dividend; |Remainder| < |B|.
  - Divide by zero: `Quotient` = all ones, `Remainder` = A, `div_by_zero` = 1.
  - Overflow case: `Quotient` = −2^(nb−1) (wraps), `Remainder` = 0, `overflow` = 1.
  - Both flags are cleared on every other FIX.
- Outputs hold their values through DONE and IDLE until the next FIX or a reset.

## Timing
- `start` is sampled at edge E0.
- Normal divide:
  - `ready` falls after E0.
  - RUN steps occur at E1..Enb.
  - FIX writes the outputs at E(nb+1), and `ready` rises after that edge.
  - Result: `ready` is low for exactly nb+1 cycles.
- Divide by zero: FIX occurs at E1, so `ready` is low for 1 cycle.
- Outputs change only at the FIX edge and are valid whenever `ready` = 1.
- `rst` and `start` high together: reset wins.
- `rst` mid-divide: IDLE and zeroed outputs on the next edge; partial results are discarded.
- Back-to-back: `start` asserted in the cycle `ready` rises is accepted; no dead cycle.

## Structure
- Shared package `div_pkg`:
  - state encoding localparams ST_IDLE, ST_RUN, ST_FIX, ST_DONE;
  - a function returning the counter width $clog2(nb)+1.
- Sub-module `div_step`:
  - combinational single restoring step;
  - inputs R, Q, |B|; outputs next R and next Q;
  - instantiated once and parameterised by nb.
- FSM, operand/sign registers and fix-up logic live in `seq_divider`.

## Test plan
All scenarios use nb = 8.
- A=100, B=7 → Quotient=14, Remainder=2, flags 0; `ready` low exactly 9 cycles.
- A=−100, B=7 → Quotient=−14 (0xF2), Remainder=−2 (0xFE). A=100, B=−7 → Quotient=−14, Remainder=2.
- A=−128, B=−1 → Quotient=0x80, Remainder=0, `overflow`=1. A=−128, B=1 → Quotient=0x80, `overflow`=0.
- A=5, B=0 → Quotient=0xFF, Remainder=5, `div_by_zero`=1; `ready` low 1 cycle. A following 9/3 → Quotient=3, `div_by_zero`=0.
- 50/3 started, then `start` with 77/8 on cycle 4 → Quotient=9, Remainder=5, `ready` rises 9 cycles after the second `start`.
- `rst` pulsed on cycle 5 of 100/7 → next cycle `ready`=1 and all outputs 0; `rst` together with `start` → no divide begins.
